// File: rtl/fp8_pkg.sv
// Shared FP8 minifloat definitions: field layout, bias, decoder FSM states
// and field-extraction helpers.
package fp8_pkg;

    localparam int FP8_W      = 8;
    localparam int FP8_EXP_W  = 4;
    localparam int FP8_MANT_W = 3;
    localparam int FP8_BIAS   = 7;

    localparam logic [FP8_EXP_W-1:0] FP8_EXP_SPECIAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic logic fp8_sign(input logic [FP8_W-1:0] fp);
        return fp[FP8_W-1];
    endfunction

    function automatic logic [FP8_EXP_W-1:0] fp8_exp(input logic [FP8_W-1:0] fp);
        return fp[FP8_W-2 -: FP8_EXP_W];
    endfunction

    function automatic logic [FP8_MANT_W-1:0] fp8_mant(input logic [FP8_W-1:0] fp);
        return fp[FP8_MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fp8_to_fixed_decoder.sv
// FP8 (1/4/3, bias 7) to signed fixed-point Q(INT_W).(FRAC_W) converter.
// Aligns the significand with a one-bit-per-clock shifter, then saturates,
// applies the sign and flags lost bits / overflow / NaN.
module fp8_to_fixed_decoder
    import fp8_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FP8_W-1:0]        fp_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT_W+FRAC_W-1:0] fx_out,
    output logic                    ovf,
    output logic                    inexact,
    output logic                    nan
);

    localparam int OUT_W     = INT_W + FRAC_W;
    localparam int CNT_W     = 8;
    localparam int MAX_RIGHT = 5;

    localparam logic [OUT_W-1:0] HALF_RANGE = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MOST_POS   = {1'b0, {(OUT_W-1){1'b1}}};

    state_t             state;
    logic [OUT_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               dir_left;
    logic               sign_q;
    logic               sticky;
    logic               sat;
    logic               is_nan;

    logic [FP8_EXP_W-1:0]  in_exp;
    logic [FP8_EXP_W-1:0]  in_e_eff;
    logic [FP8_MANT_W:0]   in_sig;
    logic [CNT_W-1:0]      in_count;
    logic                  in_left;
    logic                  in_special;
    logic                  fix_over;
    int                    shift_amt;
    int                    shift_mag;

    assign in_ready = (state == IDLE);

    // Decode the incoming word into significand, shift direction and step count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_exp     = fp8_exp(fp_in);
        in_sig     = {in_exp != '0, fp8_mant(fp_in)};
        in_e_eff   = (in_exp != '0) ? in_exp : FP8_EXP_W'(1);
        in_special = (in_exp == FP8_EXP_SPECIAL);
        shift_amt  = int'(in_e_eff) - (FP8_BIAS + FP8_MANT_W) + FRAC_W;
        shift_mag  = shift_amt;
        if (shift_amt < 0) begin
            shift_mag = (-shift_amt > MAX_RIGHT) ? MAX_RIGHT : -shift_amt;
        end
        in_left  = (shift_amt > 0);
        in_count = CNT_W'(shift_mag);
    end

    // Magnitude exceeds the representable range for the latched sign.
    always_comb begin
        fix_over = (!sign_q && (acc >= HALF_RANGE)) || (sign_q && (acc > HALF_RANGE));
    end

    // Conversion FSM with accumulator/counter datapath and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            dir_left  <= 1'b0;
            sign_q    <= 1'b0;
            sticky    <= 1'b0;
            sat       <= 1'b0;
            is_nan    <= 1'b0;
            out_valid <= 1'b0;
            fx_out    <= '0;
            ovf       <= 1'b0;
            inexact   <= 1'b0;
            nan       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= fp8_sign(fp_in);
                        acc      <= OUT_W'(in_sig);
                        count    <= in_count;
                        dir_left <= in_left;
                        sticky   <= 1'b0;
                        sat      <= in_special && (fp8_mant(fp_in) == '0);
                        is_nan   <= in_special && (fp8_mant(fp_in) != '0);
                        state    <= (in_special || (in_count == '0)) ? FIX : SHIFT;
                    end
                end
                SHIFT: begin
                    if (dir_left && acc[OUT_W-1]) begin
                        // Another left step would drop the top bit: saturate now.
                        sat   <= 1'b1;
                        state <= FIX;
                    end else begin
                        if (dir_left) begin
                            acc <= acc << 1;
                        end else begin
                            acc    <= acc >> 1;
                            sticky <= sticky | acc[0];
                        end
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    out_valid <= 1'b1;
                    state     <= OUT;
                    if (is_nan) begin
                        fx_out  <= '0;
                        ovf     <= 1'b0;
                        inexact <= 1'b0;
                        nan     <= 1'b1;
                    end else if (sat || fix_over) begin
                        fx_out  <= sign_q ? HALF_RANGE : MOST_POS;
                        ovf     <= 1'b1;
                        inexact <= 1'b0;
                        nan     <= 1'b0;
                    end else begin
                        fx_out  <= sign_q ? (~acc + OUT_W'(1)) : acc;
                        ovf     <= 1'b0;
                        inexact <= sticky;
                        nan     <= 1'b0;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
